dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the byte-addressed, word-wide data memory (combinational little-endian 32-bit read at any address, 4-byte write on posedge). It shares the memory between port 0 (CPU load/store unit) and port 1 (loader/DMA) with round-robin fairness. It converts RISC-V byte, halfword and word loads and stores into aligned word accesses, using read-modify-write for sub-word stores. It sits between the requesters and the data memory; the memory itself is unchanged.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data memory.
// Requester side: req is a level held until ack; ack is a one-cycle pulse qualifying err and rdata.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [2:0]            p0_funct3;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_err;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [2:0]            p1_funct3;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_err;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
    input  mem_rd,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
    output mem_rd,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the data memory; turns RISC-V byte/half/word
// loads and stores into aligned word accesses, using read-modify-write for sub-word stores.
module dmem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = 32'h20000
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  last_grant;
  logic                  cur_port;
  logic                  t_we;
  logic [2:0]            t_f3;
  logic [ADDR_WIDTH-1:0] t_addr;
  logic [DATA_WIDTH-1:0] t_wdata;
  logic [DATA_WIDTH-1:0] merge_q;
  logic                  ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                  gnt_valid, gnt_port, g_we, g_bad;
  logic [2:0]            g_f3;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] shifted, load_val, merged;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_a_c;
  logic [DATA_WIDTH-1:0] mem_wd_c;

  // No grant while any ack is high, so a held req cannot double-grant and
  // two back-to-back requesters alternate with a one-cycle gap.
  always_comb begin
    gnt_valid = (state == IDLE) && !ack0_q && !ack1_q && (bus.p0_req || bus.p1_req);
    gnt_port  = (bus.p0_req && bus.p1_req) ? ~last_grant : bus.p1_req;
    g_we      = gnt_port ? bus.p1_we     : bus.p0_we;
    g_f3      = gnt_port ? bus.p1_funct3 : bus.p0_funct3;
    g_addr    = gnt_port ? bus.p1_addr   : bus.p0_addr;
    g_wdata   = gnt_port ? bus.p1_wdata  : bus.p0_wdata;
    g_bad     = (g_f3 == 3'b011) || (g_f3[2:1] == 2'b11) || (g_we && g_f3[2])
             || (g_addr >= MEM_BYTES)
             || ((g_f3[1:0] == 2'b01) && g_addr[0])
             || ((g_f3[1:0] == 2'b10) && (g_addr[1:0] != 2'b00));
  end

  // Lane selection; alignment is already guaranteed, so one shift serves bytes and halves.
  always_comb begin
    lane_shift = {t_addr[1:0], 3'b000};
    shifted    = bus.mem_rd >> lane_shift;
    case (t_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = bus.mem_rd;
    endcase
    merged = bus.mem_rd;
    if (t_f3[1:0] == 2'b00) merged[lane_shift +: 8]  = t_wdata[7:0];
    else                    merged[lane_shift +: 16] = t_wdata[15:0];
  end

  // mem_we is gated by rst so a reset during WRITE leaves memory untouched.
  always_comb begin
    state_next = state;
    mem_we_c   = 1'b0;
    mem_a_c    = '0;
    mem_wd_c   = '0;
    case (state)
      IDLE: begin
        if (gnt_valid && !g_bad) state_next = ACCESS;
      end
      ACCESS: begin
        mem_a_c = {t_addr[ADDR_WIDTH-1:2], 2'b00};
        if (t_we && (t_f3[1:0] == 2'b10)) begin
          mem_we_c   = ~rst;
          mem_wd_c   = t_wdata;
          state_next = IDLE;
        end else if (t_we) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_a_c    = {t_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_we_c   = ~rst;
        mem_wd_c   = merge_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      t_we       <= 1'b0;
      t_f3       <= 3'b000;
      t_addr     <= '0;
      t_wdata    <= '0;
      merge_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state  <= state_next;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur_port   <= gnt_port;
            last_grant <= gnt_port;
            t_we       <= g_we;
            t_f3       <= g_f3;
            t_addr     <= g_addr;
            t_wdata    <= g_wdata;
            if (g_bad) begin
              if (gnt_port) begin
                ack1_q <= 1'b1; err1_q <= 1'b1; rdata1_q <= '0;
              end else begin
                ack0_q <= 1'b1; err0_q <= 1'b1; rdata0_q <= '0;
              end
            end
          end
        end
        ACCESS: begin
          if (!t_we) begin
            if (cur_port) begin ack1_q <= 1'b1; rdata1_q <= load_val; end
            else          begin ack0_q <= 1'b1; rdata0_q <= load_val; end
          end else if (t_f3[1:0] == 2'b10) begin
            if (cur_port) ack1_q <= 1'b1;
            else          ack0_q <= 1'b1;
          end else begin
            merge_q <= merged;
          end
        end
        WRITE: begin
          if (cur_port) ack1_q <= 1'b1;
          else          ack0_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.p0_ack   = ack0_q;
  assign bus.p0_err   = err0_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_ack   = ack1_q;
  assign bus.p1_err   = err1_q;
  assign bus.p1_rdata = rdata1_q;
  assign bus.mem_we   = mem_we_c;
  assign bus.mem_a    = mem_a_c;
  assign bus.mem_wd   = mem_wd_c;
  assign state_dbg    = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural word memory, per-port transaction task,
// hand-computed expectations for loads, stores, errors, round-robin and reset during RMW.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state_dbg;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];

  logic        pl_en;
  logic [31:0] pl_a, pl_d;
  logic [31:0] mem [0:32767];

  int          lat, we_n, we_first;
  logic [31:0] rd;
  logic        er;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(32'h20000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[16:2]];

  always @(posedge clk) begin
    if (pl_en)           mem[pl_a[16:2]]      <= pl_d;
    else if (bus.mem_we) mem[bus.mem_a[16:2]] <= bus.mem_wd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive(input bit port, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // lat counts edges from the grant edge (1) to the edge that raises ack
  task automatic do_op(input bit port, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic a;
    drive(port, 1'b1, we, f3, addr, wdata);
    lat = 0; we_n = 0; we_first = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.mem_we) begin
        we_n++;
        if (we_first == 0) we_first = i;
      end
      a = port ? bus.p1_ack : bus.p0_ack;
      if (a) begin
        lat = i;
        rd  = port ? bus.p1_rdata : bus.p0_rdata;
        er  = port ? bus.p1_err   : bus.p0_err;
        break;
      end
    end
    if (port) bus.p1_req = 1'b0;
    else      bus.p0_req = 1'b0;
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack0"},   32'(bus.p0_ack), 32'd0);
    check({tag, "_ack1"},   32'(bus.p1_ack), 32'd0);
    check({tag, "_err0"},   32'(bus.p0_err), 32'd0);
    check({tag, "_err1"},   32'(bus.p1_err), 32'd0);
    check({tag, "_rdata0"}, bus.p0_rdata,    32'd0);
    check({tag, "_rdata1"}, bus.p1_rdata,    32'd0);
    check({tag, "_we"},     32'(bus.mem_we), 32'd0);
    check({tag, "_a"},      bus.mem_a,       32'd0);
    check({tag, "_wd"},     bus.mem_wd,      32'd0);
    check({tag, "_state"},  32'(state_dbg),  32'd0);
  endtask

  // stimulus + scoreboard
  initial begin
    bit          e_port [5];
    logic        e_we   [5];
    logic [2:0]  e_f3   [5];
    logic [31:0] e_addr [5];
    logic [7:0]  pb;
    int          served;

    rst   = 1'b1;
    pl_en = 1'b0;
    pl_a  = '0;
    pl_d  = '0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    do_reset();
    check_quiet("reset");

    preload(32'h10000, 32'h11223344);
    preload(32'h10008, 32'hCAFEF00D);
    preload(32'h1FFFC, 32'h5A5A5A5A);

    do_op(1'b0, 1'b0, 3'b010, 32'h10000, 32'd0);
    check("lw_lat", lat, 2);
    check("lw_rd", rd, 32'h11223344);
    check("lw_err", 32'(er), 32'd0);
    check("lw_we", we_n, 0);

    preload(32'h10000, 32'h88223344);
    do_op(1'b1, 1'b0, 3'b000, 32'h10003, 32'd0);
    check("lb_lat", lat, 2);
    check("lb_rd", rd, 32'hFFFFFF88);
    do_op(1'b1, 1'b0, 3'b100, 32'h10003, 32'd0);
    check("lbu_rd", rd, 32'h00000088);
    do_op(1'b0, 1'b0, 3'b001, 32'h10002, 32'd0);
    check("lh_rd", rd, 32'hFFFF8822);
    do_op(1'b0, 1'b0, 3'b101, 32'h10000, 32'd0);
    check("lhu_rd", rd, 32'h00003344);
    do_op(1'b1, 1'b0, 3'b010, 32'h1FFFC, 32'd0);
    check("lw_top_rd", rd, 32'h5A5A5A5A);
    check("lw_top_err", 32'(er), 32'd0);

    preload(32'h10004, 32'hAABBCCDD);
    do_op(1'b0, 1'b1, 3'b000, 32'h10005, 32'h00000055);
    check("sb_lat", lat, 3);
    check("sb_we_n", we_n, 1);
    check("sb_we_at", we_first, 2);
    check("sb_mem", mem[32'h10004 >> 2], 32'hAABB55DD);

    preload(32'h10004, 32'hAABBCCDD);
    do_op(1'b0, 1'b1, 3'b001, 32'h10006, 32'h00001234);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[32'h10004 >> 2], 32'h1234CCDD);

    do_op(1'b1, 1'b1, 3'b010, 32'h10008, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_we_at", we_first, 1);
    check("sw_mem", mem[32'h10008 >> 2], 32'hDEADBEEF);

    do_op(1'b0, 1'b0, 3'b010, 32'h10004, 32'd0);
    check("lw_back_rd", rd, 32'h1234CCDD);

    e_port[0] = 1'b1; e_we[0] = 1'b0; e_f3[0] = 3'b010; e_addr[0] = 32'h10002;
    e_port[1] = 1'b0; e_we[1] = 1'b0; e_f3[1] = 3'b001; e_addr[1] = 32'h10001;
    e_port[2] = 1'b1; e_we[2] = 1'b0; e_f3[2] = 3'b010; e_addr[2] = 32'h20000;
    e_port[3] = 1'b0; e_we[3] = 1'b0; e_f3[3] = 3'b011; e_addr[3] = 32'h10000;
    e_port[4] = 1'b1; e_we[4] = 1'b1; e_f3[4] = 3'b100; e_addr[4] = 32'h10000;
    for (int i = 0; i < 5; i++) begin
      do_op(e_port[i], e_we[i], e_f3[i], e_addr[i], 32'hFFFFFFFF);
      check($sformatf("err%0d_lat", i), lat, 1);
      check($sformatf("err%0d_err", i), 32'(er), 32'd1);
      check($sformatf("err%0d_rd", i), rd, 32'd0);
      check($sformatf("err%0d_we", i), we_n, 0);
    end
    check("err_mem_kept", mem[32'h10000 >> 2], 32'h88223344);

    // round-robin: entries are {port, edge index, rdata[15:0]}
    preload(32'h10000, 32'h11223344);
    preload(32'h10008, 32'hCAFEF00D);
    do_reset();
    exp_q.push_back({8'd0, 8'd1,  16'h3344});
    exp_q.push_back({8'd1, 8'd4,  16'hF00D});
    exp_q.push_back({8'd0, 8'd7,  16'h3344});
    exp_q.push_back({8'd1, 8'd10, 16'hF00D});
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10000, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10008, 32'd0);
    served = 0;
    for (int idx = 0; idx < 16; idx++) begin
      tick();
      if (bus.p0_ack || bus.p1_ack) begin
        pb = bus.p1_ack ? 8'd1 : 8'd0;
        if (bus.p0_ack && bus.p1_ack) pb = 8'hFF;
        served++;
        if (exp_q.size() == 0)
          check("rr_extra", {pb, 8'(idx), bus.p1_ack ? bus.p1_rdata[15:0] : bus.p0_rdata[15:0]}, 32'd0);
        else
          check("rr_ack", {pb, 8'(idx), bus.p1_ack ? bus.p1_rdata[15:0] : bus.p0_rdata[15:0]},
                exp_q.pop_front());
        if (served == 4) begin
          bus.p0_req = 1'b0;
          bus.p1_req = 1'b0;
        end
      end
    end
    check("rr_left", exp_q.size(), 0);

    // reset while the sub-word store is in WRITE
    preload(32'h10004, 32'hAABBCCDD);
    drive(1'b0, 1'b1, 1'b1, 3'b000, 32'h10004, 32'h00000077);
    tick();
    tick();
    check("rmw_in_write_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    bus.p0_req = 1'b0;
    tick();
    check_quiet("rmw_reset");
    check("rmw_reset_mem", mem[32'h10004 >> 2], 32'hAABBCCDD);
    rst = 1'b0;
    tick();
    check("rmw_after_ack", 32'(bus.p0_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
